// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//  - fifo_ptr_w / fifo_cnt_w : derive pointer and occupancy widths from depth
//  - fifo_status_t           : bundle of status/handshake flags, reusable by
//                              monitors and benches
package fifo_sync_param_pkg;

    // Pointer width: pointers wrap naturally modulo the (power-of-two) depth.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one extra bit so that "full" (count == depth) is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
//  master : the side driving requests (flush, wr_en, data_in, rd_en, levels)
//  slave  : the FIFO itself, returning data, pulses, flags, count, max_count
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

    logic                  flush;
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [CNT_W-1:0]      af_level;
    logic [CNT_W-1:0]      ae_level;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      max_count;

    modport master (
        output flush, wr_en, data_in, rd_en, af_level, ae_level,
        input  data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count, max_count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, af_level, ae_level,
        output data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count, max_count
    );

endinterface

// File: rtl/fifo_sync_param_ram.sv
// Storage array of the FIFO: one synchronous write port, one asynchronous
// read port, no reset (contents are only meaningful between the pointers).
//  clk   : clock
//  we    : write enable
//  waddr : write address
//  wdata : write data
//  raddr : read address
//  rdata : read data (combinational from raddr)
module fifo_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// levels, occupancy count, sticky high-water mark, synchronous flush and
// selectable standard or first-word-fall-through read.
//  clk   : rising-edge clock
//  rst_n : synchronous active-low reset
//  bus   : slave side of fifo_sync_param_if (requests in, data/status out)
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit FWFT       = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);
    localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [CNT_W-1:0]      max_count_reg, max_count_next;
    logic [FIFO_WIDTH-1:0] data_out_reg;
    logic [FIFO_WIDTH-1:0] ram_rd_data;
    logic                  wr_ack_reg, overflow_reg, underflow_reg;
    logic                  wr_acc, rd_acc, ram_we;
    fifo_status_t          status;

    // Acceptance is decided on the pre-edge flags, so a simultaneous
    // write+read at full becomes read-only and at empty becomes write-only.
    assign status.full        = (count_reg == DEPTH_C);
    assign status.empty       = (count_reg == '0);
    assign status.almostfull  = (count_reg >= bus.af_level);
    assign status.almostempty = (count_reg <= bus.ae_level);
    assign status.wr_ack      = wr_ack_reg;
    assign status.overflow    = overflow_reg;
    assign status.underflow   = underflow_reg;

    assign wr_acc = bus.wr_en && !status.full;
    assign rd_acc = bus.rd_en && !status.empty;
    assign ram_we = rst_n && !bus.flush && wr_acc;

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CNT_W'(1);
        end
        max_count_next = (count_next > max_count_reg) ? count_next : max_count_reg;
    end

    fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .ADDR_W(PTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr_reg),
        .wdata(bus.data_in),
        .raddr(rd_ptr_reg),
        .rdata(ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            max_count_reg <= '0;
            wr_ack_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            max_count_reg <= '0;
            wr_ack_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg     <= count_next;
            max_count_reg <= max_count_next;
            wr_ack_reg    <= wr_acc;
            overflow_reg  <= bus.wr_en && status.full;
            underflow_reg <= bus.rd_en && status.empty;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown live while non-empty; the register tracks it
            // so the last shown word stays on data_out once the FIFO drains.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_out_reg <= '0;
                end else if (!status.empty) begin
                    data_out_reg <= ram_rd_data;
                end
            end
            assign bus.data_out = status.empty ? data_out_reg : ram_rd_data;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_out_reg <= '0;
                end else if (!bus.flush && rd_acc) begin
                    data_out_reg <= ram_rd_data;
                end
            end
            assign bus.data_out = data_out_reg;
        end
    endgenerate

    assign bus.full        = status.full;
    assign bus.empty       = status.empty;
    assign bus.almostfull  = status.almostfull;
    assign bus.almostempty = status.almostempty;
    assign bus.wr_ack      = status.wr_ack;
    assign bus.overflow    = status.overflow;
    assign bus.underflow   = status.underflow;
    assign bus.count       = count_reg;
    assign bus.max_count   = max_count_reg;

endmodule
